// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC source/enable and IF/ID, ID/EX controls for boot, stall, branch, return and halt.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush event counters.
module fetch_ctrl #(
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req,
    input  logic        br_taken,
    input  logic        ret_req,
    input  logic        ret_valid,
    input  logic        halt_req,
    output logic [1:0]  PCSrc,
    output logic        PC_we,
    output logic        IFID_we,
    output logic        IFID_flush,
    output logic        IDEX_flush,
    output logic [1:0]  state,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_BOOT     = 2'b00,
        S_RUN      = 2'b01,
        S_RET_WAIT = 2'b10,
        S_HALT     = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_EX   = 2'b01,
        PC_RET  = 2'b10,
        PC_HOLD = 2'b11
    } pcsrc_e;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] boot_cnt_q, boot_cnt_d;
    pcsrc_e     pcsrc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_BOOT;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        unique case (state_q)
            S_BOOT: begin
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == BOOT_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                // Priority order matters: an older return beats a branch, which beats halt.
                if (ret_req)       state_d = S_RET_WAIT;
                else if (br_taken) state_d = S_RUN;
                else if (halt_req) state_d = S_HALT;
            end
            S_RET_WAIT: begin
                if (ret_valid) state_d = S_RUN;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        pcsrc      = PC_HOLD;
        PC_we      = 1'b0;
        IFID_we    = 1'b0;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            S_BOOT: IFID_flush = 1'b1;
            S_RUN: begin
                if (ret_req) begin
                    IFID_flush = 1'b1;
                    IDEX_flush = 1'b1;
                end else if (br_taken) begin
                    pcsrc      = PC_EX;
                    PC_we      = 1'b1;
                    IFID_flush = 1'b1;
                    IDEX_flush = 1'b1;
                end else if (!halt_req) begin
                    if (stall_req) begin
                        IDEX_flush = 1'b1;
                    end else begin
                        pcsrc   = PC_INC;
                        PC_we   = 1'b1;
                        IFID_we = 1'b1;
                    end
                end
            end
            S_RET_WAIT: begin
                IFID_flush = 1'b1;
                IDEX_flush = 1'b1;
                if (ret_valid) begin
                    pcsrc = PC_RET;
                    PC_we = 1'b1;
                end
            end
            S_HALT: begin
                IDEX_flush = 1'b1;
                halted     = 1'b1;
            end
            default: IFID_flush = 1'b1;
        endcase
    end

    assign PCSrc = pcsrc;
    assign state = state_q;

`ifdef FETCH_PERF_CNT_EN
    logic        stall_evt, flush_evt;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_evt   = (state_q == S_RUN) && !ret_req && !br_taken && !halt_req && stall_req;
        flush_evt   = (state_q == S_RUN) && (ret_req || br_taken);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
